// File: rtl/plab4_net_demux_buf_pkg.sv
// plab4_net_demux_buf_pkg: shared constants and helpers for the per-domain demux
// Holds the drop counter width/saturation value and the domain range check.
package plab4_net_demux_buf_pkg;
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;
  function automatic logic dom_in_range(input int dom, input int n);
    return dom < n;
  endfunction
endpackage

// File: rtl/plab4_net_demux_buf_if.sv
// plab4_net_demux_buf_if: upstream val/rdy stream plus flattened per-domain downstream ports
// master: router side driving domain/out_*/in_rdy; slave: the demux driving out_rdy/in_*/drop_cnt.
interface plab4_net_demux_buf_if
  import plab4_net_demux_buf_pkg::*;
#(
  parameter int p_msg_cnbits  = 32,
  parameter int p_msg_dnbits  = 32,
  parameter int p_num_domains = 2,
  parameter int p_dom_bits    = $clog2(p_num_domains)
);
  logic [p_dom_bits-1:0]                 domain;
  logic                                  out_val;
  logic                                  out_rdy;
  logic [p_msg_cnbits-1:0]               out_msg_control;
  logic [p_msg_dnbits-1:0]               out_msg_data;
  logic [p_num_domains-1:0]              in_val;
  logic [p_num_domains-1:0]              in_rdy;
  logic [p_num_domains*p_msg_cnbits-1:0] in_msg_control;
  logic [p_num_domains*p_msg_dnbits-1:0] in_msg_data;
  logic [DROP_CNT_W-1:0]                 drop_cnt;
  modport master (
    output domain, out_val, out_msg_control, out_msg_data, in_rdy,
    input  out_rdy, in_val, in_msg_control, in_msg_data, drop_cnt
  );
  modport slave (
    input  domain, out_val, out_msg_control, out_msg_data, in_rdy,
    output out_rdy, in_val, in_msg_control, in_msg_data, drop_cnt
  );
endinterface

// File: rtl/plab4_net_demux_buf_queue.sv
// plab4_net_demux_buf_queue: single-domain val/rdy FIFO, zero-filled output when empty
// Ports: clk, reset (async active-low), enq_val/enq_rdy/enq_msg in, deq_val/deq_rdy/deq_msg out.
module plab4_net_demux_buf_queue #(
  parameter int p_width = 64,
  parameter int p_depth = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_width-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_width-1:0] deq_msg
);
  localparam int AW = $clog2(p_depth);
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_cnt;
  logic [p_width-1:0] r_mem [p_depth];
  logic               w_enq, w_deq;
  assign enq_rdy = r_cnt != (AW+1)'(p_depth);
  assign deq_val = r_cnt != '0;
  assign w_enq   = enq_val && enq_rdy;
  assign w_deq   = deq_val && deq_rdy;
  assign deq_msg = deq_val ? r_mem[r_rptr] : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + AW'(1);
      if (w_deq) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_deq);
    end
  // Storage needs no reset: empty entries are never shown thanks to the zero-fill.
  always_ff @(posedge clk)
    if (w_enq) r_mem[r_wptr] <= enq_msg;
endmodule

// File: rtl/plab4_net_demux_buf.sv
// plab4_net_demux_buf: steers one val/rdy stream into per-domain FIFOs, sinking out-of-range tags
// Ports: clk, reset (async active-low), bus (slave side of plab4_net_demux_buf_if).
module plab4_net_demux_buf
  import plab4_net_demux_buf_pkg::*;
#(
  parameter int p_msg_cnbits  = 32,
  parameter int p_msg_dnbits  = 32,
  parameter int p_num_domains = 2,
  parameter int p_buf_depth   = 2,
  parameter int p_dom_bits    = $clog2(p_num_domains)
) (
  input logic                  clk,
  input logic                  reset,
  plab4_net_demux_buf_if.slave bus
);
  localparam int W  = p_msg_cnbits + p_msg_dnbits;
  localparam int NP = 2 ** p_dom_bits;
  logic                     w_in_range, w_fire;
  logic [p_num_domains-1:0] w_enq_rdy, w_deq_val;
  logic [NP-1:0]            w_rdy_pad;
  logic [W-1:0]             w_deq_msg [p_num_domains];
  logic [DROP_CNT_W-1:0]    r_drop_cnt;
  assign w_in_range = dom_in_range(int'(bus.domain), p_num_domains);
  // Pad readiness to the full tag range so an out-of-range tag never indexes past the array.
  assign w_rdy_pad  = NP'(w_enq_rdy);
  assign bus.out_rdy = reset && (!w_in_range || w_rdy_pad[bus.domain]);
  assign w_fire     = bus.out_val && bus.out_rdy;
  for (genvar i = 0; i < p_num_domains; i++) begin : g_dom
    plab4_net_demux_buf_queue #(.p_width(W), .p_depth(p_buf_depth)) u_q (
      .clk     (clk),
      .reset   (reset),
      .enq_val (w_fire && bus.domain == p_dom_bits'(i)),
      .enq_rdy (w_enq_rdy[i]),
      .enq_msg ({bus.out_msg_control, bus.out_msg_data}),
      .deq_val (w_deq_val[i]),
      .deq_rdy (bus.in_rdy[i]),
      .deq_msg (w_deq_msg[i])
    );
  end
  assign bus.in_val   = w_deq_val;
  assign bus.drop_cnt = r_drop_cnt;
  always_comb begin
    bus.in_msg_control = '0;
    bus.in_msg_data    = '0;
    for (int k = 0; k < p_num_domains; k++) begin
      bus.in_msg_control[k*p_msg_cnbits +: p_msg_cnbits] = w_deq_msg[k][W-1 -: p_msg_cnbits];
      bus.in_msg_data[k*p_msg_dnbits +: p_msg_dnbits]    = w_deq_msg[k][p_msg_dnbits-1:0];
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_drop_cnt <= '0;
    else if (w_fire && !w_in_range && r_drop_cnt != DROP_CNT_MAX) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
endmodule
